bridge_frame_decoder: RTL and testbench

- Target-side parser of the UART bus bridge.
- Consumes the byte stream from the UART receiver, reassembles read/write request frames and validates the checksum.
- Presents each good request to the local bus initiator with a valid/ready handshake.
- Sits between uart_rx and the bus master port on the remote (LED-owning) FPGA.

---
 rtl/bridge_frame_decoder.sv | 107 ++++++++++
 tb/tb_bridge_frame_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bridge_frame_decoder.sv
// bridge_frame_decoder: UART bridge request frame parser with checksum and timeout (optional stats via BRIDGE_FRAME_DECODER_STATS_EN)
module bridge_frame_decoder #(
  parameter int ADDR_W = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_wdata,
  output logic              err_pulse,
  output logic [1:0]        err_code
`ifdef BRIDGE_FRAME_DECODER_STATS_EN
  ,
  output logic [15:0]       stat_good,
  output logic [15:0]       stat_bad
`endif
);
  localparam int NB = ADDR_W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, DATA = 3'd2, CSUM = 3'd3, ISSUE = 3'd4;
  logic [2:0] state;
  logic [ADDR_W-1:0] addr_s;
  logic [7:0] wdata_s, csum;
  logic wr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic accept, is_cmd, wait_st, tmo, bad_cmd, bad_sum, err;
  assign in_ready = state != ISSUE;
  assign req_valid = state == ISSUE;
  assign accept = in_valid && in_ready;
  assign is_cmd = in_data == 8'h57 || in_data == 8'h52;
  assign wait_st = state == ADDR || state == DATA || state == CSUM;
  assign tmo = wait_st && !accept && timer == TW'(TIMEOUT_CYCLES - 1);
  assign bad_cmd = state == IDLE && accept && !is_cmd;
  assign bad_sum = state == CSUM && accept && in_data != csum;
  assign err = bad_cmd || bad_sum || tmo;
  // Frame assembly; the request fields only change when a frame's checksum matches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      addr_s <= '0;
      wdata_s <= '0;
      csum <= '0;
      wr <= 1'b0;
      cnt <= '0;
      timer <= '0;
      req_write <= 1'b0;
      req_addr <= '0;
      req_wdata <= '0;
      err_pulse <= 1'b0;
      err_code <= '0;
    end else begin
      err_pulse <= err;
      if (err) err_code <= bad_cmd ? 2'd1 : bad_sum ? 2'd2 : 2'd3;
      timer <= (accept || !wait_st || tmo) ? '0 : timer + 1'b1;
      case (state)
        IDLE: if (accept && is_cmd) begin
          wr <= in_data == 8'h57;
          csum <= in_data;
          cnt <= '0;
          state <= ADDR;
        end
        ADDR: if (accept) begin
          addr_s <= (addr_s << 8) | ADDR_W'(in_data);
          csum <= csum ^ in_data;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NB - 1)) state <= wr ? DATA : CSUM;
        end
        DATA: if (accept) begin
          wdata_s <= in_data;
          csum <= csum ^ in_data;
          state <= CSUM;
        end
        CSUM: if (accept) begin
          state <= bad_sum ? IDLE : ISSUE;
          if (!bad_sum) begin
            req_write <= wr;
            req_addr <= addr_s;
            req_wdata <= wr ? wdata_s : 8'h00;
          end
        end
        ISSUE: if (req_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (tmo) state <= IDLE;
    end
  end
`ifdef BRIDGE_FRAME_DECODER_STATS_EN
  // Saturating counts of handshaken requests and flagged errors
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_good <= '0;
      stat_bad <= '0;
    end else begin
      if (req_valid && req_ready && stat_good != 16'hFFFF) stat_good <= stat_good + 1'b1;
      if (err && stat_bad != 16'hFFFF) stat_bad <= stat_bad + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_bridge_frame_decoder.sv
// tb_bridge_frame_decoder: directed self-checking bench for bridge_frame_decoder
module tb_bridge_frame_decoder;
  logic clk = 0, rstn = 0, in_valid = 0, req_ready = 1;
  logic [7:0] in_data = 0;
  logic in_ready, req_valid, req_write, err_pulse;
  logic [15:0] req_addr;
  logic [7:0] req_wdata;
  logic [1:0] err_code;
  int passed = 0, total = 0, exp_good = 0, exp_bad = 0;
`ifdef BRIDGE_FRAME_DECODER_STATS_EN
  logic [15:0] stat_good, stat_bad;
`endif
  bridge_frame_decoder #(.ADDR_W(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .err_pulse(err_pulse), .err_code(err_code)
`ifdef BRIDGE_FRAME_DECODER_STATS_EN
    , .stat_good(stat_good), .stat_bad(stat_bad)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    in_valid = 1;
    in_data = b;
    tick();
    in_valid = 0;
  endtask
  task automatic test_reset();
    rstn = 0;
    tick();
    total++;
    if ({in_ready, req_valid, req_write, req_addr, req_wdata, err_pulse, err_code} !== {1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 2'd0})
      $display("FAIL reset: got rdy=%b v=%b w=%b a=%h d=%h ep=%b ec=%0d want 1 0 0 0000 00 0 0", in_ready, req_valid, req_write, req_addr, req_wdata, err_pulse, err_code);
    else passed++;
    rstn = 1;
    tick();
  endtask
  task automatic test_write();
    req_ready = 1;
    send(8'h57); send(8'h00); send(8'h10); send(8'hA5); send(8'hE2);
    exp_good++;
    total++;
    if ({req_valid, req_write, req_addr, req_wdata, in_ready} !== {1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0})
      $display("FAIL write_req: got v=%b w=%b a=%h d=%h rdy=%b want 1 1 0010 a5 0", req_valid, req_write, req_addr, req_wdata, in_ready);
    else passed++;
    tick();
    total++;
    if ({req_valid, in_ready} !== 2'b01) $display("FAIL write_pulse: got v=%b rdy=%b want 0 1", req_valid, in_ready);
    else passed++;
  endtask
  task automatic test_read_hold();
    int bad = 0;
    req_ready = 0;
    send(8'h52); send(8'h00); send(8'h10); send(8'h42);
    in_valid = 1;
    in_data = 8'h57;
    for (int i = 0; i < 20; i++) begin
      if ({req_valid, req_write, req_addr, req_wdata, in_ready} !== {1'b1, 1'b0, 16'h0010, 8'h00, 1'b0}) bad++;
      tick();
    end
    in_valid = 0;
    total++;
    if (bad !== 0) $display("FAIL read_hold: got %0d unstable cycles want 0 (v=%b a=%h)", bad, req_valid, req_addr);
    else passed++;
    req_ready = 1;
    tick();
    exp_good++;
    total++;
    if ({req_valid, in_ready} !== 2'b01) $display("FAIL read_release: got v=%b rdy=%b want 0 1", req_valid, in_ready);
    else passed++;
  endtask
  task automatic test_bad_csum();
    send(8'h57); send(8'h00); send(8'h10); send(8'hA5); send(8'h00);
    exp_bad++;
    total++;
    if ({err_pulse, err_code, req_valid, req_addr, req_wdata} !== {1'b1, 2'd2, 1'b0, 16'h0010, 8'h00})
      $display("FAIL bad_csum: got ep=%b ec=%0d v=%b a=%h d=%h want 1 2 0 0010 00", err_pulse, err_code, req_valid, req_addr, req_wdata);
    else passed++;
    tick();
    total++;
    if ({err_pulse, err_code, req_valid} !== {1'b0, 2'd2, 1'b0}) $display("FAIL bad_csum_once: got ep=%b ec=%0d v=%b want 0 2 0", err_pulse, err_code, req_valid);
    else passed++;
    send(8'h57); send(8'h00); send(8'h20); send(8'h11); send(8'h66);
    exp_good++;
    total++;
    if ({req_valid, req_write, req_addr, req_wdata} !== {1'b1, 1'b1, 16'h0020, 8'h11})
      $display("FAIL after_bad: got v=%b w=%b a=%h d=%h want 1 1 0020 11", req_valid, req_write, req_addr, req_wdata);
    else passed++;
    tick();
  endtask
  task automatic test_stray();
    send(8'h33);
    exp_bad++;
    total++;
    if ({err_pulse, err_code} !== {1'b1, 2'd1}) $display("FAIL stray: got ep=%b ec=%0d want 1 1", err_pulse, err_code);
    else passed++;
    send(8'h52); send(8'h00); send(8'h10); send(8'h42);
    exp_good++;
    total++;
    if ({req_valid, req_write, req_addr, req_wdata, err_pulse} !== {1'b1, 1'b0, 16'h0010, 8'h00, 1'b0})
      $display("FAIL stray_read: got v=%b w=%b a=%h d=%h ep=%b want 1 0 0010 00 0", req_valid, req_write, req_addr, req_wdata, err_pulse);
    else passed++;
    tick();
  endtask
  task automatic test_timeout();
    int n = 0;
    send(8'h57); send(8'h00);
    while (n < 150 && !err_pulse) begin
      tick();
      n++;
    end
    exp_bad++;
    total++;
    if ({n, err_code} !== {32'd100, 2'd3}) $display("FAIL timeout: got cycles=%0d ec=%0d want 100 3", n, err_code);
    else passed++;
    send(8'h52); send(8'h12); send(8'h34); send(8'h74);
    exp_good++;
    total++;
    if ({req_valid, req_write, req_addr, req_wdata} !== {1'b1, 1'b0, 16'h1234, 8'h00})
      $display("FAIL timeout_next: got v=%b w=%b a=%h d=%h want 1 0 1234 00", req_valid, req_write, req_addr, req_wdata);
    else passed++;
    tick();
  endtask
  task automatic test_timeout_edge();
    int errs = 0;
    send(8'h57); send(8'h00);
    for (int i = 0; i < 99; i++) begin
      tick();
      if (err_pulse) errs++;
    end
    send(8'h10);
    if (err_pulse) errs++;
    send(8'hA5); send(8'hE2);
    if (err_pulse) errs++;
    exp_good++;
    total++;
    if ({errs, req_valid, req_addr, req_wdata} !== {32'd0, 1'b1, 16'h0010, 8'hA5})
      $display("FAIL timeout_edge: got errs=%0d v=%b a=%h d=%h want 0 1 0010 a5", errs, req_valid, req_addr, req_wdata);
    else passed++;
    tick();
  endtask
`ifdef BRIDGE_FRAME_DECODER_STATS_EN
  task automatic test_stats();
    total++;
    if ({stat_good, stat_bad} !== {exp_good[15:0], exp_bad[15:0]})
      $display("FAIL stats: got good=%0d bad=%0d want %0d %0d", stat_good, stat_bad, exp_good, exp_bad);
    else passed++;
  endtask
`endif
  task automatic test_reset_mid();
    int errs = 0;
    send(8'h57); send(8'h00);
    rstn = 0;
    #2;
    total++;
    if ({in_ready, req_valid, req_addr, err_pulse, err_code} !== {1'b1, 1'b0, 16'h0, 1'b0, 2'd0})
      $display("FAIL reset_addr: got rdy=%b v=%b a=%h ep=%b ec=%0d want 1 0 0000 0 0", in_ready, req_valid, req_addr, err_pulse, err_code);
    else passed++;
    tick();
    rstn = 1;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (err_pulse || req_valid) errs++;
    end
    total++;
    if (errs !== 0) $display("FAIL reset_addr_quiet: got %0d event cycles want 0", errs);
    else passed++;
    req_ready = 0;
    send(8'h52); send(8'h12); send(8'h34); send(8'h74);
    total++;
    if ({req_valid, req_addr} !== {1'b1, 16'h1234}) $display("FAIL pre_reset_issue: got v=%b a=%h want 1 1234", req_valid, req_addr);
    else passed++;
    rstn = 0;
    #2;
    total++;
    if ({in_ready, req_valid, req_write, req_addr, req_wdata, err_pulse, err_code} !== {1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 2'd0})
      $display("FAIL reset_issue: got rdy=%b v=%b w=%b a=%h d=%h ep=%b ec=%0d want 1 0 0 0000 00 0 0", in_ready, req_valid, req_write, req_addr, req_wdata, err_pulse, err_code);
    else passed++;
    tick();
    rstn = 1;
    req_ready = 1;
    tick();
    total++;
    if ({req_valid, err_pulse} !== 2'b00) $display("FAIL reset_issue_quiet: got v=%b ep=%b want 0 0", req_valid, err_pulse);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_bad_csum();
    test_stray();
    test_timeout();
    test_timeout_edge();
`ifdef BRIDGE_FRAME_DECODER_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
